// File: rtl/mem_access_sequencer.sv
// Multi-channel memory access sequencer.
// Round-robin arbitration of NUM_CH requesters onto one memory port, with a
// bounded-wait timeout that returns an error response to the requester.
module mem_access_sequencer #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MASK_W  = DATA_W / 8,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH-1:0]          ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    input  logic [NUM_CH*MASK_W-1:0]   ch_wmask,
    output logic [NUM_CH-1:0]          ch_resp,
    output logic [NUM_CH-1:0]          ch_err,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [MASK_W-1:0]          mem_byte_enable,
    output logic                       mem_read,
    output logic                       mem_write,
    input  logic                       mem_resp,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       busy
);

    localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value on the last permitted ACCESS cycle
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_q;
    logic [ID_W-1:0]   rr_q;
    logic [ID_W-1:0]   grant_q;
    logic              write_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [MASK_W-1:0] mem_be_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [NUM_CH-1:0] ch_resp_q;
    logic [NUM_CH-1:0] ch_err_q;
    logic [DATA_W-1:0] ch_rdata_q;
    logic              busy_q;

    logic              gnt_valid_d;
    logic [ID_W-1:0]   gnt_id_d;
    logic [ID_W-1:0]   rr_d;
    logic              skip_d;
    logic              timeout_hit;

    logic [ADDR_W-1:0] addr_arr  [NUM_CH];
    logic [DATA_W-1:0] wdata_arr [NUM_CH];
    logic [MASK_W-1:0] wmask_arr [NUM_CH];

    // Split the flattened channel buses into per-channel operands
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign addr_arr[gi]  = ch_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = ch_wdata[gi*DATA_W +: DATA_W];
            assign wmask_arr[gi] = ch_wmask[gi*MASK_W +: MASK_W];
        end
    endgenerate

    // Round-robin pick: first requester at or after the pointer, wrapping
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_id;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
        cand        = 0;
        cand_id     = '0;
        // Scan from farthest to nearest so the nearest requester wins
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = int'(rr_q) + i;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            cand_id = ID_W'(cand);
            if (ch_req[cand_id]) begin
                gnt_valid_d = 1'b1;
                gnt_id_d    = cand_id;
            end
        end
        rr_d        = (gnt_id_d == ID_W'(NUM_CH - 1)) ? '0 : gnt_id_d + ID_W'(1);
        // A write with no byte lanes enabled never touches memory
        skip_d      = ch_write[gnt_id_d] && (wmask_arr[gnt_id_d] == '0);
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    end

    // Sequencer FSM; every output is a register updated here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_q          <= '0;
            grant_q       <= '0;
            write_q       <= 1'b0;
            cnt_q         <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            ch_resp_q     <= '0;
            ch_err_q      <= '0;
            ch_rdata_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            ch_resp_q <= '0;
            ch_err_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid_d) begin
                        grant_q       <= gnt_id_d;
                        rr_q          <= rr_d;
                        write_q       <= ch_write[gnt_id_d];
                        mem_address_q <= addr_arr[gnt_id_d];
                        mem_wdata_q   <= wdata_arr[gnt_id_d];
                        mem_be_q      <= ch_write[gnt_id_d] ? wmask_arr[gnt_id_d] : '1;
                        cnt_q         <= '0;
                        busy_q        <= 1'b1;
                        if (skip_d) begin
                            ch_resp_q[gnt_id_d] <= 1'b1;
                            state_q             <= ST_RESP;
                        end else begin
                            mem_read_q  <= !ch_write[gnt_id_d];
                            mem_write_q <= ch_write[gnt_id_d];
                            state_q     <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_resp) begin
                        mem_read_q         <= 1'b0;
                        mem_write_q        <= 1'b0;
                        ch_resp_q[grant_q] <= 1'b1;
                        if (!write_q) begin
                            ch_rdata_q <= mem_rdata;
                        end
                        state_q <= ST_RESP;
                    end else if (timeout_hit) begin
                        mem_read_q         <= 1'b0;
                        mem_write_q        <= 1'b0;
                        ch_resp_q[grant_q] <= 1'b1;
                        ch_err_q[grant_q]  <= 1'b1;
                        ch_rdata_q         <= '0;
                        state_q            <= ST_RESP;
                    end else if (TIMEOUT != 0) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ch_resp         = ch_resp_q;
    assign ch_err          = ch_err_q;
    assign ch_rdata        = ch_rdata_q;
    assign mem_address     = mem_address_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_byte_enable = mem_be_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign busy            = busy_q;

endmodule
